psum_accum: RTL and testbench

- Consumer end of the 3x3 PE row output. Accepts one vector of 9 Q24.8 partial sums per handshake and accumulates ACC_NUM successive vectors (3 kernel rows x input channels) element-wise.
- Then applies optional ReLU and presents the finished 9-pixel output row on a registered valid/ready port to the output-fmap writer.
- Sits between the PE array and the output buffer.

---
 rtl/pe_pkg.sv | 16 +
 rtl/psum_accum_sat_add.sv | 19 +
 rtl/psum_accum.sv | 104 ++++++++++
 tb/tb_psum_accum.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared Q24.8 lane definitions for the PE output path.
// Lanes are packed little-end first: lane k occupies [k*DW +: DW].
package pe_pkg;
    localparam int Q_IW = 24;
    localparam int Q_FW = 8;
    localparam int DW   = Q_IW + Q_FW;

    typedef logic signed [DW-1:0] q_lane_t;

    localparam q_lane_t Q_MAX = 32'h7FFFFFFF;
    localparam q_lane_t Q_MIN = 32'h80000000;
endpackage

`ifndef PE_LANE
`define PE_LANE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

// File: rtl/psum_accum_sat_add.sv
// Signed lane adder that clamps to the Q24.8 range instead of wrapping.
module sat_add
    import pe_pkg::*;
(
    input  q_lane_t a_i,
    input  q_lane_t b_i,
    output q_lane_t y_o
);
    logic [DW:0] sum;

    always_comb begin
        sum = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};
        y_o = sum[DW-1:0];
        // Top two bits disagree only when the true result left the DW range.
        if (sum[DW] != sum[DW-1]) begin
            y_o = sum[DW] ? Q_MIN : Q_MAX;
        end
    end
endmodule

// File: rtl/psum_accum.sv
// Accumulates ACC_NUM partial-sum vectors per output row, applies optional
// ReLU, and hands the finished row to the output writer over valid/ready.
module psum_accum
    import pe_pkg::*;
#(
    parameter int OUTPUT_NUM = 9,
    parameter int IW         = 24,
    parameter int FW         = 8,
    parameter int ACC_NUM    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         relu_en_i,
    input  logic [OUTPUT_NUM*(IW+FW)-1:0] psum_i,
    input  logic                         psum_valid_i,
    output logic                         psum_ready_o,
    output logic [OUTPUT_NUM*(IW+FW)-1:0] res_o,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic                         busy_o
);
    localparam int DW = IW + FW;
    localparam int CW = $clog2(ACC_NUM) + 1;
    localparam logic [CW-1:0] LAST = CW'(ACC_NUM - 1);

    logic [CW-1:0]            cnt_q, cnt_d;
    logic [OUTPUT_NUM*DW-1:0] acc_q, acc_d;
    logic [OUTPUT_NUM*DW-1:0] res_q, res_d;
    logic [OUTPUT_NUM*DW-1:0] sum;
    logic                     res_valid_q, res_valid_d;

    logic is_first, is_last, beat, final_beat;

    assign is_first     = (cnt_q == '0);
    assign is_last      = (cnt_q == LAST);
    // Only the row-completing beat needs the output register to be free.
    assign psum_ready_o = !is_last || !res_valid_q || res_ready_i;
    assign beat         = psum_valid_i && psum_ready_o;
    assign final_beat   = beat && is_last && !clr_i;

    for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_lane
        q_lane_t addend;
        // First beat of a row loads: adding to zero cannot saturate.
        assign addend = is_first ? '0 : `PE_LANE(acc_q, k, DW);
        sat_add u_sat_add (
            .a_i (addend),
            .b_i (`PE_LANE(psum_i, k, DW)),
            .y_o (`PE_LANE(sum, k, DW))
        );
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;

        if (res_ready_i) begin
            res_valid_d = 1'b0;
        end

        if (clr_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (beat) begin
            if (is_last) begin
                cnt_d       = '0;
                res_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
                acc_d = sum;
            end
        end

        if (final_beat) begin
            for (int k = 0; k < OUTPUT_NUM; k++) begin
                if (relu_en_i && sum[k*DW + DW - 1]) begin
                    res_d[k*DW +: DW] = '0;
                end else begin
                    res_d[k*DW +: DW] = sum[k*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_o       = res_q;
    assign res_valid_o = res_valid_q;
    assign busy_o      = (cnt_q != '0);
endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: directed scenarios plus a randomized run
// checked against a row-level arithmetic model.
module tb_psum_accum;
    localparam int N   = 9;
    localparam int DW  = 32;
    localparam int ACC = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr_i;
    logic            relu_en_i;
    logic [N*DW-1:0] psum_i;
    logic            psum_valid_i;
    logic            psum_ready_o;
    logic [N*DW-1:0] res_o;
    logic            res_valid_o;
    logic            res_ready_i;
    logic            busy_o;

    psum_accum #(.OUTPUT_NUM(N), .IW(24), .FW(8), .ACC_NUM(ACC)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr_i),
        .relu_en_i    (relu_en_i),
        .psum_i       (psum_i),
        .psum_valid_i (psum_valid_i),
        .psum_ready_o (psum_ready_o),
        .res_o        (res_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     lane_v [N];
    int     m_n;
    longint m_sum  [N];
    int     m_row  [N];
    bit     m_valid;

    function automatic int lane_of(input logic [N*DW-1:0] vec, input int k);
        return int'(vec[k*DW +: DW]);
    endfunction

    function automatic void set_all(input int v);
        for (int k = 0; k < N; k++) lane_v[k] = v;
    endfunction

    function automatic void model_reset();
        m_n     = 0;
        m_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_sum[k] = 0;
            m_row[k] = 0;
        end
    endfunction

    // Row-level reference: running sums clamp to the 32-bit signed range.
    function automatic void model_beat(input bit relu);
        for (int k = 0; k < N; k++) begin
            longint s;
            s = (m_n == 0) ? 0 : m_sum[k];
            s = s + longint'(lane_v[k]);
            if (s > 64'sd2147483647)  s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
            m_sum[k] = s;
        end
        m_n++;
        if (m_n == ACC) begin
            for (int k = 0; k < N; k++)
                m_row[k] = (relu && m_sum[k] < 0) ? 0 : int'(m_sum[k]);
            m_valid = 1'b1;
            m_n     = 0;
        end
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input bit v, input bit rr, input bit relu, input bit clr,
                       output bit acc, output bit rdy);
        bit drain;
        psum_valid_i = v;
        res_ready_i  = rr;
        relu_en_i    = relu;
        clr_i        = clr;
        for (int k = 0; k < N; k++) psum_i[k*DW +: DW] = lane_v[k];
        #1;
        rdy   = psum_ready_o;
        acc   = v && rdy;
        drain = m_valid && rr;
        @(posedge clk);
        if (drain) m_valid = 1'b0;
        if (clr) begin
            m_n = 0;
            for (int k = 0; k < N; k++) m_sum[k] = 0;
        end else if (acc) begin
            model_beat(relu);
        end
        @(negedge clk);
        psum_valid_i = 1'b0;
        clr_i        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_i = 0; relu_en_i = 0; psum_i = '0;
        psum_valid_i = 0; res_ready_i = 0;
        model_reset();
        #3;
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || res_o !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b res=%h required 0/0/0", res_valid_o, busy_o, res_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (psum_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", psum_ready_o);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit a, r;
        set_all(256);
        cyc(1, 1, 0, 0, a, r);
        checks++;
        if (busy_o !== 1'b1 || res_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_beat1: busy=%b valid=%b required 1/0", busy_o, res_valid_o);
        end
        set_all(512);
        cyc(1, 1, 0, 0, a, r);
        checks++;
        if (busy_o !== 1'b1 || res_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_beat2: busy=%b valid=%b required 1/0", busy_o, res_valid_o);
        end
        set_all(-128);
        cyc(1, 1, 0, 0, a, r);
        checks++;
        if (res_valid_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: valid=%b busy=%b required 1/0", res_valid_o, busy_o);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (lane_of(res_o, k) !== 640) begin
                errors++;
                $display("FAIL basic_lane%0d: got %0d required 640", k, lane_of(res_o, k));
            end
        end
        cyc(0, 1, 0, 0, a, r);
        checks++;
        if (res_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_single_pulse: valid=%b required 0", res_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        bit a, r;
        int vals [6];
        vals = '{1, 2, 3, 10, 20, 30};
        for (int i = 0; i < 5; i++) begin
            set_all(vals[i]);
            cyc(1, 0, 0, 0, a, r);
            checks++;
            if (a !== 1'b1) begin
                errors++;
                $display("FAIL bp_accept%0d: accepted=%b required 1", i + 1, a);
            end
        end
        for (int s = 0; s < 2; s++) begin
            set_all(vals[5]);
            cyc(1, 0, 0, 0, a, r);
            checks++;
            if (r !== 1'b0 || a !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall: ready=%b required 0", r);
            end
            checks++;
            if (res_valid_o !== 1'b1 || lane_of(res_o, 4) !== 6 || lane_of(res_o, 0) !== 6) begin
                errors++;
                $display("FAIL bp_hold: valid=%b lane0=%0d required 1/6", res_valid_o, lane_of(res_o, 0));
            end
        end
        set_all(vals[5]);
        cyc(1, 1, 0, 0, a, r);
        checks++;
        if (a !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: accepted=%b required 1", a);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (res_valid_o !== 1'b1 || lane_of(res_o, k) !== 60) begin
                errors++;
                $display("FAIL bp_row2_lane%0d: valid=%b got %0d required 60", k, res_valid_o, lane_of(res_o, k));
            end
        end
        cyc(0, 1, 0, 0, a, r);
    endtask

    task automatic test_saturation();
        bit a, r;
        set_all(0);
        lane_v[0] = 32'h7FFFFF00; lane_v[1] = 32'h80000000;
        cyc(1, 1, 0, 0, a, r);
        lane_v[0] = 32'h00000200; lane_v[1] = 32'hFFFFFF00;
        cyc(1, 1, 0, 0, a, r);
        set_all(0);
        cyc(1, 1, 0, 0, a, r);
        checks++;
        if (res_o[0 +: DW] !== 32'h7FFFFFFF) begin
            errors++;
            $display("FAIL sat_pos: got %h required 7fffffff", res_o[0 +: DW]);
        end
        checks++;
        if (res_o[DW +: DW] !== 32'h80000000) begin
            errors++;
            $display("FAIL sat_neg: got %h required 80000000", res_o[DW +: DW]);
        end
        checks++;
        if (lane_of(res_o, 2) !== 0) begin
            errors++;
            $display("FAIL sat_other: got %0d required 0", lane_of(res_o, 2));
        end
        cyc(0, 1, 0, 0, a, r);
    endtask

    task automatic test_relu();
        bit a, r;
        set_all(0);
        lane_v[0] = -100; lane_v[1] = 100;
        cyc(1, 1, 1, 0, a, r);
        cyc(1, 1, 0, 0, a, r);
        cyc(1, 1, 1, 0, a, r);
        checks++;
        if (lane_of(res_o, 0) !== 0 || lane_of(res_o, 1) !== 300) begin
            errors++;
            $display("FAIL relu_on: got %0d/%0d required 0/300", lane_of(res_o, 0), lane_of(res_o, 1));
        end
        cyc(1, 1, 1, 0, a, r);
        cyc(1, 1, 1, 0, a, r);
        cyc(1, 1, 0, 0, a, r);
        checks++;
        if (lane_of(res_o, 0) !== -300 || lane_of(res_o, 1) !== 300) begin
            errors++;
            $display("FAIL relu_off_final: got %0d/%0d required -300/300", lane_of(res_o, 0), lane_of(res_o, 1));
        end
        cyc(0, 1, 0, 0, a, r);
    endtask

    task automatic test_clr();
        bit a, r;
        set_all(100);
        cyc(1, 1, 0, 0, a, r);
        cyc(1, 1, 0, 0, a, r);
        cyc(1, 1, 0, 1, a, r);
        checks++;
        if (a !== 1'b1 || res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_abort: acc=%b valid=%b busy=%b required 1/0/0", a, res_valid_o, busy_o);
        end
        set_all(1);
        cyc(1, 1, 0, 0, a, r);
        cyc(1, 1, 0, 0, a, r);
        checks++;
        if (res_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_early: valid=%b required 0", res_valid_o);
        end
        cyc(1, 1, 0, 0, a, r);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (res_valid_o !== 1'b1 || lane_of(res_o, k) !== 3) begin
                errors++;
                $display("FAIL clr_next_lane%0d: valid=%b got %0d required 3", k, res_valid_o, lane_of(res_o, k));
            end
        end
        cyc(0, 1, 0, 0, a, r);
    endtask

    task automatic test_async_reset();
        bit a, r;
        set_all(5);
        repeat (3) cyc(1, 0, 0, 0, a, r);
        set_all(9);
        cyc(1, 0, 0, 0, a, r);
        checks++;
        if (res_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup: valid=%b busy=%b required 1/1", res_valid_o, busy_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || res_o !== '0) begin
            errors++;
            $display("FAIL arst_immediate: valid=%b busy=%b res=%h required 0", res_valid_o, busy_o, res_o);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_all(7);
        repeat (3) cyc(1, 1, 0, 0, a, r);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (res_valid_o !== 1'b1 || lane_of(res_o, k) !== 21) begin
                errors++;
                $display("FAIL arst_clean_lane%0d: valid=%b got %0d required 21", k, res_valid_o, lane_of(res_o, k));
            end
        end
        cyc(0, 1, 0, 0, a, r);
    endtask

    task automatic test_random();
        bit a, r, v, rr, relu, clr, exp_rdy;
        for (int c = 0; c < 400; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            rr   = ($urandom_range(0, 2) != 0);
            relu = $urandom_range(0, 1) != 0;
            clr  = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) lane_v[k] = int'($urandom);
                else                           lane_v[k] = int'($urandom_range(0, 2000)) - 1000;
            end
            exp_rdy = !(m_n == ACC - 1 && m_valid && !rr);
            cyc(v, rr, relu, clr, a, r);
            checks++;
            if (r !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready cyc%0d: got %b required %b", c, r, exp_rdy);
            end
            checks++;
            if (res_valid_o !== m_valid || busy_o !== (m_n != 0)) begin
                errors++;
                $display("FAIL rand_flags cyc%0d: valid=%b busy=%b required %b/%b", c, res_valid_o, busy_o, m_valid, m_n != 0);
            end
            if (m_valid) begin
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (lane_of(res_o, k) !== m_row[k]) begin
                        errors++;
                        $display("FAIL rand_lane%0d cyc%0d: got %0d required %0d", k, c, lane_of(res_o, k), m_row[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_relu();
        test_clr();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
